// File: rtl/pc_bpred.sv
// Fetch PC unit with a direct-mapped BTB and 2-bit saturating direction counters.
// Taken branches are redirected at fetch; EX resolution corrects mispredicts through flush.
module pc_bpred #(
  parameter int WIDTH     = 16,
  parameter int IDX_BITS  = 4,
  parameter int INC       = 2,
  parameter int RESET_VEC = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] pc_nx,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             flush,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int               ENTRIES = 1 << IDX_BITS;
  localparam int               TAG_W   = WIDTH - IDX_BITS - 1;
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);

  typedef enum logic [1:0] {
    SEL_FLUSH,
    SEL_HOLD,
    SEL_PRED,
    SEL_SEQ
  } pc_sel_e;

  // Predictor state: valid bits and counters are reset, tag/target arrays are not.
  logic [ENTRIES-1:0]      valid_q;
  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [TAG_W-1:0]        tag_mem [ENTRIES];
  logic [WIDTH-1:0]        tgt_mem [ENTRIES];

  // ---------------------------------------------------------------------------
  // Fetch-side lookup (sees pre-update contents in a same-cycle update)
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;

  assign idx         = addr[IDX_BITS:1];
  assign tag         = addr[WIDTH-1:IDX_BITS+1];
  assign hit         = valid_q[idx] & (tag_mem[idx] == tag);
  assign pred_taken  = hit & ctr_q[idx][1];
  assign pred_target = tgt_mem[idx];
  assign pc_nx       = addr + INC_W;

  // ---------------------------------------------------------------------------
  // Mispredict detection and corrected PC
  // ---------------------------------------------------------------------------
  logic             upd;
  logic             dir_mis;
  logic             tgt_mis;
  logic [WIDTH-1:0] fix_pc;

  assign upd     = ex_valid & ex_is_br;
  assign dir_mis = ex_taken != ex_pred_taken;
  assign tgt_mis = ex_taken & ex_pred_taken & (ex_target != ex_pred_target);
  assign flush   = upd & (dir_mis | tgt_mis);
  assign fix_pc  = ex_taken ? ex_target : ex_pc + INC_W;

  // ---------------------------------------------------------------------------
  // Next-PC selection: flush > stall > prediction > sequential
  // ---------------------------------------------------------------------------
  pc_sel_e          pc_sel;
  logic [WIDTH-1:0] addr_nx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (flush)           pc_sel = SEL_FLUSH;
    else if (!en)        pc_sel = SEL_HOLD;
    else if (pred_taken) pc_sel = SEL_PRED;
  end

  always_comb begin
    addr_nx = pc_nx;
    unique case (pc_sel)
      SEL_FLUSH: addr_nx = fix_pc;
      SEL_HOLD:  addr_nx = addr;
      SEL_PRED:  addr_nx = pred_target;
      SEL_SEQ:   addr_nx = pc_nx;
      default:   addr_nx = pc_nx;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr <= RST_PC;
    else      addr <= addr_nx;
  end

  // ---------------------------------------------------------------------------
  // Resolve-side predictor update
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] ridx;
  logic [TAG_W-1:0]    rtag;
  logic                r_hit;
  logic [1:0]          ctr_upd;

  assign ridx  = ex_pc[IDX_BITS:1];
  assign rtag  = ex_pc[WIDTH-1:IDX_BITS+1];
  assign r_hit = valid_q[ridx] & (tag_mem[ridx] == rtag);

  always_comb begin
    ctr_upd = ctr_q[ridx];
    if (ex_taken) begin
      if (ctr_q[ridx] != 2'b11) ctr_upd = ctr_q[ridx] + 2'd1;
    end else begin
      if (ctr_q[ridx] != 2'b00) ctr_upd = ctr_q[ridx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else if (upd) begin
      if (r_hit) begin
        ctr_q[ridx] <= ctr_upd;
      end else if (ex_taken) begin
        valid_q[ridx] <= 1'b1;
        ctr_q[ridx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target arrays carry no reset; an entry is only read as a hit once its valid bit is set.
  always_ff @(posedge clk) begin
    if (upd && ex_taken) begin
      tgt_mem[ridx] <= ex_target;
      if (!r_hit) tag_mem[ridx] <= rtag;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating mispredict counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             mispred_cnt <= '0;
    else if (flush && mispred_cnt != '1)  mispred_cnt <= mispred_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pc_bpred.md
Name: pc_bpred

Overview:
- Parametrised next-generation fetch PC unit.
- Holds the PC and generates PC+INC.
- Adds dynamic branch prediction: a direct-mapped BTB plus a 2-bit saturating counter per entry, so taken branches redirect at fetch instead of at resolve.
- Accepts branch/jump resolution from EX, raises flush with the corrected PC on mispredict, and counts mispredicts.
- Sits between the fetch stage (drives instruction memory address) and EX (resolution).

Parameters:
- WIDTH, 16, address/PC width in bits.
- IDX_BITS, 4, BTB index bits; entries = 2**IDX_BITS.
- INC, 2, sequential PC increment in bytes.
- RESET_VEC, 0, PC value after reset.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  fetch advance; 0 = stall (PC holds unless flush).
- addr  output  WIDTH  current fetch PC.
- pc_nx  output  WIDTH  addr+INC, modulo 2**WIDTH.
- pred_taken  output  1  fetch-time prediction for addr.
- pred_target  output  WIDTH  predicted target (valid when pred_taken=1).
- ex_valid  input  1  EX holds a resolved control-flow instruction.
- ex_is_br  input  1  resolved instruction is a branch or jump (updates predictor).
- ex_pc  input  WIDTH  PC of the resolved instruction.
- ex_taken  input  1  actual direction.
- ex_target  input  WIDTH  actual taken target.
- ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- ex_pred_target  input  WIDTH  predicted target carried down the pipe.
- flush  output  1  mispredict; younger instructions must be squashed.
- mispred_cnt  output  CNT_W  saturating count of mispredicts.

Behaviour:
- Async reset (rst=0):
  - addr=RESET_VEC.
  - All BTB valid bits cleared; all counters set to 2'b01 (weakly not-taken).
  - mispred_cnt=0.
  - flush is combinational and therefore 0 while ex_valid=0.
- Reset assertion mid-operation takes effect immediately, without waiting for a clock edge. The first fetch after release is RESET_VEC.
- Lookup is combinational on addr:
  - idx=addr[IDX_BITS:1] (bit 0 ignored, halfword aligned).
  - tag=addr[WIDTH-1:IDX_BITS+1].
  - hit = valid[idx] & (tag_mem[idx]==tag).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = tgt_mem[idx].
- Mispredict detection is combinational:
  - flush = ex_valid & ex_is_br & ((ex_taken!=ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target!=ex_pred_target)).
  - Correct PC = ex_taken ? ex_target : ex_pc+INC.
- Next-PC priority, registered at the rising edge:
  1. flush=1: correct PC. Overrides en=0.
  2. en=0: hold addr.
  3. pred_taken=1: pred_target.
  4. Otherwise: pc_nx.
- Predictor update at the rising edge when ex_valid & ex_is_br (independent of en), at resolve index ridx=ex_pc[IDX_BITS:1]:
  - Resolve hit, taken: ctr saturating increment (max 2'b11); tgt_mem updated to ex_target.
  - Resolve hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Resolve miss, taken: allocate the entry (valid=1, tag, target) with ctr=2'b10, replacing any occupant.
  - Resolve miss, not taken: no allocation, no change.
- Same-cycle lookup and update of the same index: lookup sees the pre-update contents; the new contents are visible from the next cycle.
- mispred_cnt increments by 1 on each cycle with flush=1 and saturates at all-ones.
- Arithmetic:
  - All PC additions wrap modulo 2**WIDTH, so 16'hFFFE+2 = 16'h0000.
  - No carry output.

Test Plan:
- Reset: hold rst=0, then release with en=1 and no resolves → addr=0, then 2, 4, 6 on successive edges; pred_taken=0 throughout; mispred_cnt=0.
- Cold taken branch: ex_valid=1, ex_is_br=1, ex_pc=0x0010, ex_taken=1, ex_target=0x0040, ex_pred_taken=0 → flush=1 that cycle; next addr=0x0040; mispred_cnt=1; entry 8 valid with ctr=2'b10. When addr returns to 0x0010 → pred_taken=1, pred_target=0x0040, next addr=0x0040.
- Counter training: from ctr=2'b10, two not-taken resolves at 0x0010 with ex_pred_taken=1 → flush each time, ctr 10→01→00; next addr=0x0012 after each; pred_taken at 0x0010 becomes 0 after the first. A third not-taken resolve stays at 00 with no flush (ex_pred_taken=0).
- Stall vs flush: en=0 holds addr at 0x0020 for 3 cycles. A mispredict asserted while en=0 (ex_taken=1, ex_target=0x0100, ex_pred_taken=0) → addr=0x0100 at the next edge despite the stall.
- Target mispredict and aliasing:
  - Predicted taken to 0x0040 but resolved taken to 0x0060 → flush=1; addr=0x0060; tgt_mem updated.
  - A taken resolve at ex_pc=0x0030 (same idx 8, different tag) replaces the entry; a lookup at 0x0010 then gives pred_taken=0.
- Wrap, saturation and async reset: addr=16'hFFFE with en=1 → 16'h0000. Force 2**CNT_W+3 flushes → mispred_cnt stays at 16'hFFFF. Assert rst=0 between clock edges → addr=0 and mispred_cnt=0 immediately.
